// File: rtl/uartprobe_pkg.sv
// Shared definitions for the uartprobe UART blocks: FSM encoding, oversampling
// constants and the mid-bit majority vote.
package uartprobe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;

  localparam logic [3:0] SampleFirst = 4'd7;
  localparam logic [3:0] SampleMid   = 4'd8;
  localparam logic [3:0] SampleLast  = 4'd9;
  localparam logic [3:0] SampleEnd   = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uartprobe_baud_tick.sv
// Free-running sample-tick divider: one-cycle tick every Div clocks,
// synchronously clearable to re-align on a start edge.
module uartprobe_baud_tick #(
  parameter int unsigned Div = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uartprobe_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and a
// valid/ready holding register; framing errors and overruns pulse for one cycle.
module uartprobe_uart_rx
  import uartprobe_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       m_areset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int unsigned DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

  if (OVERSAMPLE != UART_OVERSAMPLE) begin : g_bad_oversample
    $error("uartprobe_uart_rx: OVERSAMPLE must be 16");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uartprobe_uart_rx: clocks per sample tick must be >= 2");
  end

  logic       sync_q, rx_s_q;
  rx_state_e  state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       s7_q, s7_d, s8_q, s8_d, bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       tick, tick_clr, maj;

  uartprobe_baud_tick #(
    .Div (DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (m_areset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign maj = majority3(s7_q, s8_q, rx_s_q);

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    bit_d    = bit_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    tick_clr = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    if (tick) begin
      samp_d = samp_q + 4'd1;
      if (samp_q == SampleFirst) s7_d  = rx_s_q;
      if (samp_q == SampleMid)   s8_d  = rx_s_q;
      if (samp_q == SampleLast)  bit_d = maj;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d  = StStart;
          tick_clr = 1'b1;
          samp_d   = '0;
        end
      end
      StStart: begin
        if (tick && samp_q == SampleLast && maj) begin
          state_d = StIdle;
        end else if (tick && samp_q == SampleEnd) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (tick && samp_q == SampleEnd) begin
          shreg_d[idx_q] = bit_q;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        // Decide at mid-stop so a slightly fast sender's next start bit is not missed.
        if (tick && samp_q == SampleLast) begin
          if (maj) begin
            state_d = StIdle;
            if (!valid_q || rx_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            state_d = StBreak;
            ferr_d  = 1'b1;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (m_areset) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= StIdle;
      samp_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      bit_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= uart_rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// Directed bench for uartprobe_uart_rx at DIV=10 (160 clocks per bit).
module tb_uartprobe_uart_rx;

  logic       clk;
  logic       m_areset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0] got_mem [0:255];
  int got_n = 0, valid_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
  int b_got, b_val, b_fe, b_ov;
  logic [7:0] exp_bytes [0:15];

  uartprobe_uart_rx #(
    .CLK_HZ (1600000),
    .BAUD   (10000)
  ) dut (
    .clk          (clk),
    .m_areset     (m_areset),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cyc++;
    if (rx_valid && rx_ready) begin
      got_mem[got_n[7:0]] = rx_data;
      got_n++;
    end
    if (rx_frame_err) ferr_cyc++;
    if (rx_overrun) ovr_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mark();
    b_got = got_n;
    b_val = valid_cyc;
    b_fe  = ferr_cyc;
    b_ov  = ovr_cyc;
  endtask

  // flip: invert the line around one of the three mid-bit samples of each data bit
  // (offsets 80/90/100 after bit start line up with samples 7/8/9).
  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop,
                            input bit flip, input int nbits, input int last_len);
    logic [9:0] fr;
    logic       v;
    int         ctr, len;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      len = (k == nbits - 1) ? last_len : bclk;
      for (int c = 0; c < len; c++) begin
        v = fr[k];
        if (flip && k >= 1 && k <= 8) begin
          ctr = 80 + 10 * ((k - 1) % 3);
          if (c >= ctr - 4 && c <= ctr + 4) v = ~v;
        end
        uart_rx = v;
        cyc(1);
      end
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_areset = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    cyc(4);
    m_areset = 1'b0;
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_busy", rx_busy, 1'b0);
    check_eq("rst_ferr", rx_frame_err, 1'b0);
    check_eq("rst_ovr", rx_overrun, 1'b0);
    cyc(20);

    // Single byte
    mark();
    send_frame(8'hA5, 160, 1'b1, 1'b0, 10, 160);
    cyc(20);
    check_eq("single_count", got_n - b_got, 1);
    check_eq("single_data", got_mem[b_got[7:0]], 8'hA5);
    check_eq("single_valid_width", valid_cyc - b_val, 1);
    check_eq("single_ferr", ferr_cyc - b_fe, 0);
    check_eq("single_ovr", ovr_cyc - b_ov, 0);
    check_eq("single_busy", rx_busy, 1'b0);

    // Back-to-back with backpressure
    rx_ready = 1'b0;
    mark();
    send_frame(8'h00, 160, 1'b1, 1'b0, 10, 160);
    send_frame(8'hFF, 160, 1'b1, 1'b0, 10, 160);
    send_frame(8'h3C, 160, 1'b1, 1'b0, 10, 160);
    cyc(20);
    check_eq("bp_valid", rx_valid, 1'b1);
    check_eq("bp_data", rx_data, 8'h00);
    check_eq("bp_ovr", ovr_cyc - b_ov, 2);
    check_eq("bp_ferr", ferr_cyc - b_fe, 0);
    rx_ready = 1'b1;
    cyc(2);
    check_eq("bp_xfer_count", got_n - b_got, 1);
    check_eq("bp_xfer_data", got_mem[b_got[7:0]], 8'h00);
    check_eq("bp_valid_drop", rx_valid, 1'b0);
    cyc(20);

    // Framing error, line held low afterwards
    mark();
    send_frame(8'h55, 160, 1'b0, 1'b0, 10, 160);
    uart_rx = 1'b0;
    cyc(200);
    check_eq("fe_pulse", ferr_cyc - b_fe, 1);
    check_eq("fe_no_valid", valid_cyc - b_val, 0);
    check_eq("fe_break_busy", rx_busy, 1'b1);
    uart_rx = 1'b1;
    cyc(10);
    check_eq("fe_break_exit", rx_busy, 1'b0);
    send_frame(8'h12, 160, 1'b1, 1'b0, 10, 160);
    cyc(20);
    check_eq("fe_next_count", got_n - b_got, 1);
    check_eq("fe_next_data", got_mem[b_got[7:0]], 8'h12);
    check_eq("fe_total_ferr", ferr_cyc - b_fe, 1);

    // Glitch on idle line
    mark();
    uart_rx = 1'b0;
    cyc(40);
    uart_rx = 1'b1;
    cyc(10);
    check_eq("glitch_start_busy", rx_busy, 1'b1);
    cyc(100);
    check_eq("glitch_idle", rx_busy, 1'b0);
    check_eq("glitch_no_valid", valid_cyc - b_val, 0);
    check_eq("glitch_no_ferr", ferr_cyc - b_fe, 0);

    // One flipped mid-bit sample per data bit
    mark();
    send_frame(8'h81, 160, 1'b1, 1'b1, 10, 160);
    cyc(20);
    check_eq("vote_count", got_n - b_got, 1);
    check_eq("vote_data", got_mem[b_got[7:0]], 8'h81);
    check_eq("vote_ferr", ferr_cyc - b_fe, 0);

    // Reset 120 clocks into bit 4 of 0x6E (bit 4 is 0, so the line stays low)
    mark();
    send_frame(8'h6E, 160, 1'b1, 1'b0, 6, 120);
    uart_rx = 1'b0;
    check_eq("mrst_busy_before", rx_busy, 1'b1);
    m_areset = 1'b1;
    cyc(1);
    check_eq("mrst_busy", rx_busy, 1'b0);
    check_eq("mrst_valid", rx_valid, 1'b0);
    check_eq("mrst_data", rx_data, 8'h00);
    m_areset = 1'b0;
    cyc(40);
    check_eq("mrst_low_enters_start", rx_busy, 1'b1);
    uart_rx = 1'b1;
    cyc(300);
    check_eq("mrst_idle", rx_busy, 1'b0);
    check_eq("mrst_no_ferr", ferr_cyc - b_fe, 0);
    check_eq("mrst_no_ovr", ovr_cyc - b_ov, 0);
    check_eq("mrst_no_valid", valid_cyc - b_val, 0);
    send_frame(8'h6E, 160, 1'b1, 1'b0, 10, 160);
    cyc(20);
    check_eq("mrst_next_count", got_n - b_got, 1);
    check_eq("mrst_next_data", got_mem[b_got[7:0]], 8'h6E);

    // Baud tolerance: 156 clocks/bit (~2.5% fast) then 164 (~2.5% slow)
    for (int pass = 0; pass < 2; pass++) begin
      mark();
      for (int i = 0; i < 16; i++) begin
        exp_bytes[i] = 8'($urandom_range(0, 255));
        send_frame(exp_bytes[i], (pass == 0) ? 156 : 164, 1'b1, 1'b0, 10,
                   (pass == 0) ? 156 : 164);
      end
      cyc(50);
      check_eq(pass == 0 ? "fast_count" : "slow_count", got_n - b_got, 16);
      for (int i = 0; i < 16; i++) begin
        check_eq(pass == 0 ? "fast_byte" : "slow_byte", got_mem[8'(b_got + i)], exp_bytes[i]);
      end
      check_eq(pass == 0 ? "fast_ferr" : "slow_ferr", ferr_cyc - b_fe, 0);
      check_eq(pass == 0 ? "fast_ovr" : "slow_ovr", ovr_cyc - b_ov, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
